// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared constants, load funct3 encodings, write-request type and load formatter
// Latency: n/a (types and a pure combinational function)
// Backpressure: n/a
// Contents: XLEN, REG_AW, F3_* load encodings, wb_req_t {rd, data}, ld_format()
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Select the addressed byte/half of the aligned word and extend it.
  // Unknown encodings fall back to the full word.
  function automatic logic [XLEN-1:0] ld_format(input logic [XLEN-1:0] data,
                                                input logic [2:0]      funct3,
                                                input logic [1:0]      addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{addr_lo, 3'b000} +: 8];
    h = data[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ld_format = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  ld_format = {{(XLEN-8){1'b0}}, b};
      F3_LH:   ld_format = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  ld_format = {{(XLEN-16){1'b0}}, h};
      F3_LW:   ld_format = data;
      default: ld_format = data;
    endcase
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: ALU result, load response and register-file write port bundle
// Latency: n/a (wiring only)
// Backpressure: alu_ready / ld_ready returned by the arbiter (slave modport)
// Optional RF_WB_SCOREBOARD_EN adds iss_valid/iss_rd (to arbiter) and busy (from arbiter).
interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;

  logic              WE3;
  logic [REG_AW-1:0] A3;
  logic [XLEN-1:0]   WD3;

`ifdef RF_WB_SCOREBOARD_EN
  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [31:0]       busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  iss_valid, iss_rd,
    output alu_ready, ld_ready, WE3, A3, WD3, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output iss_valid, iss_rd,
    input  alu_ready, ld_ready, WE3, A3, WD3, busy
  );
`else
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output alu_ready, ld_ready, WE3, A3, WD3
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  alu_ready, ld_ready, WE3, A3, WD3
  );
`endif

endinterface

// File: rtl/rf_wb_ldq.sv
// rf_wb_ldq: in-order FIFO of formatted load write requests
// Latency: push visible at head_o the cycle after the push edge
// Backpressure: push ignored when full, pop ignored when empty
// Ports: clk, rst, push_i/wdat_i, pop_i, head_o, full_o, empty_o, count_o
module rf_wb_ldq
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_req_t                  wdat_i,
  input  logic                     pop_i,
  output wb_req_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdat_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU results and formatted loads onto the single RF write port (WE3/A3/WD3)
// Latency: ALU handshake -> WE3 1 cycle; load handshake -> WE3 >= 2 cycles (queued, no bypass)
// Backpressure: ALU has priority; a load waiting STARVE_LIM cycles drops alu_ready for one win; ld_ready = queue not full
// Ports: clk, rst (sync, active-high), bus (rf_wb_arbiter_if.slave). Optional macro RF_WB_SCOREBOARD_EN adds busy tracking.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int LDQ_DEPTH  = 2,
  parameter int STARVE_LIM = 4
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  wb_req_t                    ldq_wdat, ldq_head, win;
  logic                       ldq_push, ldq_pop, ldq_full, ldq_empty;
  // Queue occupancy is exported for debug visibility; the flags suffice here.
  logic [$clog2(LDQ_DEPTH):0] ldq_count_unused;

  logic                       force_ld, win_vld;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       we3_q, we3_d;
  logic [REG_AW-1:0]          a3_q, a3_d;
  logic [XLEN-1:0]            wd3_q, wd3_d;

  // Formatting happens at enqueue so the queue holds ready-to-write data.
  assign ldq_wdat = '{rd: bus.ld_rd,
                      data: ld_format(bus.ld_data, bus.ld_funct3, bus.ld_addr_lo)};
  assign bus.ld_ready = !rst && !ldq_full;
  assign ldq_push     = bus.ld_valid && bus.ld_ready;

  rf_wb_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ldq_push),
    .wdat_i  (ldq_wdat),
    .pop_i   (ldq_pop),
    .head_o  (ldq_head),
    .full_o  (ldq_full),
    .empty_o (ldq_empty),
    .count_o (ldq_count_unused)
  );

  assign force_ld      = !ldq_empty && (starve_q >= LIM);
  assign bus.alu_ready = !rst && !force_ld;

  always_comb begin
    ldq_pop = 1'b0;
    win_vld = 1'b0;
    win     = '0;
    if (!rst) begin
      if (force_ld) begin
        ldq_pop = 1'b1;
        win_vld = 1'b1;
        win     = ldq_head;
      end else if (bus.alu_valid) begin
        win_vld = 1'b1;
        win     = '{rd: bus.alu_rd, data: bus.alu_data};
      end else if (!ldq_empty) begin
        ldq_pop = 1'b1;
        win_vld = 1'b1;
        win     = ldq_head;
      end
    end
  end

  // Counts cycles the head has been passed over; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (ldq_empty || ldq_pop) starve_d = '0;
    else if (starve_q < LIM)  starve_d = starve_q + SW'(1);
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    we3_d = win_vld && (win.rd != '0);
    a3_d  = win_vld ? win.rd   : a3_q;
    wd3_d = win_vld ? win.data : wd3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      starve_q <= starve_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign bus.WE3 = we3_q;
  assign bus.A3  = a3_q;
  assign bus.WD3 = wd3_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Clear on the edge that registers the write, then set, so a same-edge issue wins.
  always_comb begin
    busy_d = busy_q;
    if (we3_d)         busy_d[a3_d]       = 1'b0;
    if (bus.iss_valid) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.busy = busy_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.LDQ_DEPTH(2), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [2:0]  f3_tab  [5];
  logic [1:0]  lo_tab  [5];
  logic [31:0] exp_tab [5];
  logic [4:0]  got_rd  [4];
  logic [31:0] got_dat [4];
  int          n_got;
  int          n_wr;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    f3_tab  = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
    lo_tab  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    exp_tab = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 4; i++) begin
      got_rd[i]  = '0;
      got_dat[i] = '0;
    end

    // Reset with both sources presenting: no handshakes allowed.
    rst            = 1'b1;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd9;
    bus.alu_data   = 32'hDEAD_BEEF;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd9;
    bus.ld_data    = 32'h1111_1111;
    bus.ld_funct3  = F3_LW;
    bus.ld_addr_lo = 2'd0;
`ifdef RF_WB_SCOREBOARD_EN
    bus.iss_valid  = 1'b0;
    bus.iss_rd     = '0;
`endif
    tick();
    tick();
    chk("rst_alu_ready", bus.alu_ready, 32'd0);
    chk("rst_ld_ready",  bus.ld_ready,  32'd0);
    chk("rst_we3",       bus.WE3,       32'd0);
    chk("rst_a3",        bus.A3,        32'd0);
    chk("rst_wd3",       bus.WD3,       32'd0);
    rst           = 1'b0;
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    #1;
    chk("post_rst_alu_ready", bus.alu_ready, 32'd1);
    chk("post_rst_ld_ready",  bus.ld_ready,  32'd1);

    // ALU write, then idle cycle holds A3/WD3.
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h0000_1234;
    #1;
    chk("alu_ready", bus.alu_ready, 32'd1);
    tick();
    chk("alu_we3", bus.WE3, 32'd1);
    chk("alu_a3",  bus.A3,  32'd5);
    chk("alu_wd3", bus.WD3, 32'h0000_1234);
    bus.alu_valid = 1'b0;
    tick();
    chk("idle_we3",     bus.WE3, 32'd0);
    chk("idle_a3_hold", bus.A3,  32'd5);
    chk("idle_wd3_hold", bus.WD3, 32'h0000_1234);

    // Load formatting, each written two cycles after its handshake.
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid   = 1'b1;
      bus.ld_rd      = 5'(10 + i);
      bus.ld_data    = 32'h80FF_7F01;
      bus.ld_funct3  = f3_tab[i];
      bus.ld_addr_lo = lo_tab[i];
      #1;
      chk("fmt_ld_ready", bus.ld_ready, 32'd1);
      tick();
      bus.ld_valid = 1'b0;
      chk("fmt_no_bypass", bus.WE3, 32'd0);
      tick();
      chk("fmt_we3", bus.WE3, 32'd1);
      chk("fmt_a3",  bus.A3,  32'(10 + i));
      chk("fmt_wd3", bus.WD3, exp_tab[i]);
    end

    // Starvation: ALU always valid, one load waits 4 cycles then pre-empts once.
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd1;
    bus.alu_data   = 32'h0000_0A1A;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd7;
    bus.ld_data    = 32'h1234_5678;
    bus.ld_funct3  = F3_LW;
    bus.ld_addr_lo = 2'd0;
    tick();
    bus.ld_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("starve_alu_ready", bus.alu_ready, (c == 5) ? 32'd0 : 32'd1);
      tick();
      if (c == 5) begin
        chk("starve_ld_we3", bus.WE3, 32'd1);
        chk("starve_ld_a3",  bus.A3,  32'd7);
        chk("starve_ld_wd3", bus.WD3, 32'h1234_5678);
      end
      if (c == 6) chk("starve_alu_resume_a3", bus.A3, 32'd1);
    end
    bus.alu_valid = 1'b0;
    tick();

    // Queue full under continuous ALU traffic; third load held until space frees.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd2;
    bus.alu_data  = 32'h0000_0022;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd20;
    bus.ld_data   = 32'h0000_000A;
    bus.ld_funct3 = F3_LW;
    #1;
    chk("full_ld_ready_a", bus.ld_ready, 32'd1);
    tick();
    bus.ld_rd   = 5'd21;
    bus.ld_data = 32'h0000_000B;
    #1;
    chk("full_ld_ready_b", bus.ld_ready, 32'd1);
    tick();
    bus.ld_rd   = 5'd22;
    bus.ld_data = 32'h0000_000C;
    for (int c = 2; c <= 5; c++) begin
      #1;
      chk("full_ld_ready_low", bus.ld_ready, 32'd0);
      tick();
    end
    chk("full_first_we3", bus.WE3, 32'd1);
    chk("full_first_a3",  bus.A3,  32'd20);
    chk("full_first_wd3", bus.WD3, 32'h0000_000A);
    #1;
    chk("full_ld_ready_back", bus.ld_ready, 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    n_got = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.WE3 && bus.A3 != 5'd2 && n_got < 4) begin
        got_rd[n_got]  = bus.A3;
        got_dat[n_got] = bus.WD3;
        n_got++;
      end
    end
    chk("full_load_count",  32'(n_got), 32'd2);
    chk("full_order_rd0",   32'(got_rd[0]), 32'd21);
    chk("full_order_dat0",  got_dat[0], 32'h0000_000B);
    chk("full_order_rd1",   32'(got_rd[1]), 32'd22);
    chk("full_order_dat1",  got_dat[1], 32'h0000_000C);
    bus.alu_valid = 1'b0;
    tick();

    // x0 suppression for both sources; later load proves the rd=0 entry was consumed.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h0000_DEAD;
    #1;
    chk("x0_alu_ready", bus.alu_ready, 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk("x0_alu_we3", bus.WE3, 32'd0);
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = 32'h0000_BEEF;
    bus.ld_funct3 = F3_LW;
    tick();
    bus.ld_rd   = 5'd9;
    bus.ld_data = 32'h0000_0099;
    tick();
    bus.ld_valid = 1'b0;
    chk("x0_ld_we3", bus.WE3, 32'd0);
    tick();
    chk("x0_next_we3", bus.WE3, 32'd1);
    chk("x0_next_a3",  bus.A3,  32'd9);
    chk("x0_next_wd3", bus.WD3, 32'h0000_0099);

    // Reset with two loads queued: they must be discarded.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h0000_0033;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd25;
    bus.ld_data   = 32'h0000_0025;
    tick();
    bus.ld_rd   = 5'd26;
    bus.ld_data = 32'h0000_0026;
    tick();
    bus.ld_valid = 1'b0;
    #1;
    chk("mid_full_ld_ready", bus.ld_ready, 32'd0);
    rst           = 1'b1;
    bus.alu_valid = 1'b0;
    #1;
    chk("mid_rst_alu_ready", bus.alu_ready, 32'd0);
    tick();
    rst = 1'b0;
    chk("mid_rst_we3", bus.WE3, 32'd0);
    chk("mid_rst_a3",  bus.A3,  32'd0);
    chk("mid_rst_wd3", bus.WD3, 32'd0);
    #1;
    chk("mid_rst_ld_ready", bus.ld_ready, 32'd1);
    n_wr = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.WE3) n_wr++;
    end
    chk("mid_rst_no_writes", 32'(n_wr), 32'd0);

    // Queue still usable after reset.
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd4;
    bus.ld_data    = 32'h0000_8001;
    bus.ld_funct3  = F3_LHU;
    bus.ld_addr_lo = 2'd0;
    tick();
    bus.ld_valid = 1'b0;
    tick();
    chk("post_rst_ld_we3", bus.WE3, 32'd1);
    chk("post_rst_ld_a3",  bus.A3,  32'd4);
    chk("post_rst_ld_wd3", bus.WD3, 32'h0000_8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
